// File: rtl/sweep_pkg.sv
// Shared definitions for the exhaustive 6-input sweep engine:
// FSM states, pattern space size and the CRC-CCITT MISR step.
package sweep_pkg;

  localparam logic [15:0] MISR_POLY    = 16'h1021;
  localparam int          PATTERN_BITS = 6;
  localparam int          NUM_PATTERNS = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  // One serial CRC-CCITT step: shift left, fold the feedback bit back in.
  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic din);
    logic fb;
    fb = sig[15] ^ din;
    return {sig[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/misr16.sv
// 16-bit serial MISR: seed load takes priority over a shift step.
module misr16
  import sweep_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        shift,
  input  logic        din,
  output logic [15:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= 16'h0000;
    end else if (load) begin
      sig <= seed;
    end else if (shift) begin
      sig <= misr_step(sig, din);
    end
  end

endmodule

// File: rtl/exhaust_sweep.sv
// Exhaustive sweep of a 6-input combinational network: every pattern is held,
// the response sampled once, and compacted into a MISR plus a ones count.
module exhaust_sweep
  import sweep_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] SIG_SEED      = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        g,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic [6:0]  ones_count
);

  localparam logic [3:0]              HOLD_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [PATTERN_BITS-1:0] LAST_P    = PATTERN_BITS'(NUM_PATTERNS - 1);

  sweep_state_t            r_state;
  sweep_state_t            w_next;
  logic [3:0]              r_hold;
  logic [PATTERN_BITS-1:0] r_p;
  logic [6:0]              r_ones;
  logic                    w_accept;
  logic                    w_shift;

  // Start is honoured only from IDLE or the DONE cycle, and abort always wins.
  assign w_accept = start && !abort && ((r_state == IDLE) || (r_state == DONE));
  assign w_shift  = (r_state == SAMPLE) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? HOLD : IDLE;
      HOLD: begin
        if (abort)                   w_next = IDLE;
        else if (r_hold == HOLD_LAST) w_next = SAMPLE;
      end
      SAMPLE: begin
        if (abort)              w_next = IDLE;
        else if (r_p == LAST_P) w_next = DONE;
        else                    w_next = HOLD;
      end
      DONE:    w_next = w_accept ? HOLD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == HOLD) || (r_state == SAMPLE);
    done = (r_state == DONE);
    {a, b, c, d, e, g} = busy ? r_p : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= 4'd0;
      r_p    <= '0;
      r_ones <= 7'd0;
    end else begin
      r_hold <= ((r_state == HOLD) && (w_next == HOLD)) ? r_hold + 4'd1 : 4'd0;
      if (w_accept) begin
        r_p    <= '0;
        r_ones <= 7'd0;
      end else if (w_shift) begin
        r_ones <= r_ones + {6'd0, f_in};
        if (r_p != LAST_P) begin
          r_p <= r_p + 1'b1;
        end
      end
    end
  end

  misr16 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_accept),
    .seed  (SIG_SEED),
    .shift (w_shift),
    .din   (f_in),
    .sig   (signature)
  );

  assign ones_count = r_ones;

endmodule

// File: tb/tb_exhaust_sweep.sv
// Directed bench for exhaust_sweep with a queue scoreboard of expected
// patterns and end-of-sweep results; three instances cover the parameter sets.
module tb_exhaust_sweep;

  localparam int          NI = 3;
  localparam int          ST [NI] = '{1, 3, 1};
  localparam logic [15:0] SD [NI] = '{16'h0000, 16'hFFFF, 16'hFFFF};

  typedef struct {
    int          n;
    logic [15:0] sig;
    logic [6:0]  ones;
  } res_t;

  logic          clk = 1'b0;
  logic [NI-1:0] rst_n, start, abort, f_in;
  logic [NI-1:0] a, b, c, d, e, g, busy, done;
  logic [15:0]   sig  [NI];
  logic [6:0]    ones [NI];

  int   checks   = 0;
  int   failures = 0;
  res_t exp_q [$];
  int   pat_q [$];

  always #5 clk = ~clk;

  exhaust_sweep #(.SETTLE_CYCLES(1), .SIG_SEED(16'h0000)) u_s1z (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .abort(abort[0]), .f_in(f_in[0]),
    .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .e(e[0]), .g(g[0]),
    .busy(busy[0]), .done(done[0]), .signature(sig[0]), .ones_count(ones[0]));

  exhaust_sweep #(.SETTLE_CYCLES(3)) u_s3 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .abort(abort[1]), .f_in(f_in[1]),
    .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]), .e(e[1]), .g(g[1]),
    .busy(busy[1]), .done(done[1]), .signature(sig[1]), .ones_count(ones[1]));

  exhaust_sweep u_dflt (
    .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .abort(abort[2]), .f_in(f_in[2]),
    .a(a[2]), .b(b[2]), .c(c[2]), .d(d[2]), .e(e[2]), .g(g[2]),
    .busy(busy[2]), .done(done[2]), .signature(sig[2]), .ones_count(ones[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pat_of(input int k);
    return int'({a[k], b[k], c[k], d[k], e[k], g[k]});
  endfunction

  function automatic logic [15:0] mstep(input logic [15:0] s, input logic bit_in);
    logic fb;
    fb = s[15] ^ bit_in;
    return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Network models: 0 = const 0, 1 = const 1, 2 = f=a, 3 = f=p[0]^p[3].
  function automatic logic fval(input int fmode, input int p);
    logic [5:0] pv;
    pv = 6'(p);
    case (fmode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return pv[5];
      default: return pv[0] ^ pv[3];
    endcase
  endfunction

  function automatic res_t model(input int k, input int fmode, input int npat);
    res_t r;
    logic fv;
    r.sig  = SD[k];
    r.ones = 7'd0;
    r.n    = 64 * (ST[k] + 1);
    for (int p = 0; p < npat; p++) begin
      fv     = fval(fmode, p);
      r.sig  = mstep(r.sig, fv);
      r.ones = r.ones + 7'(fv);
    end
    return r;
  endfunction

  task automatic push_expect(input int k, input int fmode);
    for (int p = 0; p < 64; p++)
      for (int r = 0; r <= ST[k]; r++) pat_q.push_back(p);
    exp_q.push_back(model(k, fmode, 64));
  endtask

  task automatic start_sweep(input int k, input int fmode);
    start[k] = 1'b1;
    push_expect(k, fmode);
    tick();
    start[k] = 1'b0;
  endtask

  // Called right after the accepting edge; follows the sweep cycle by cycle.
  task automatic monitor(input int k, input int fmode, input bit noisy, input int restart_n,
                         input int abort_p, input int reset_p, input bit chain);
    int   s, n, p, ep, ph;
    bit   fin;
    res_t r;
    logic fv;
    s = ST[k]; n = 0; fin = 1'b0;
    while (!fin) begin
      p  = pat_of(k);
      ph = n % (s + 1);
      if (n > 64 * (s + 1) + 4) begin
        chk("done_timeout", done[k], 1);
        fin = 1'b1;
      end else if (done[k]) begin
        chk("exp_q_size", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          chk("done_cycle", n, r.n);
          chk("signature", sig[k], r.sig);
          chk("ones_count", ones[k], r.ones);
        end
        chk("busy_at_done", busy[k], 0);
        chk("pattern_at_done", p, 0);
        chk("pat_q_left", pat_q.size(), 0);
        if (chain) start[k] = 1'b1;
        fin = 1'b1;
      end else if (!busy[k]) begin
        chk("busy_lost", busy[k], 1);
        fin = 1'b1;
      end else begin
        ep = p;
        if (pat_q.size() > 0) begin
          ep = pat_q.pop_front();
          chk("pattern", p, ep);
        end else chk("pat_q_underflow", pat_q.size(), 1);
        fv = fval(fmode, ep);
        f_in[k] = (noisy && ph != s) ? ~fv : fv;
        if (n == restart_n) start[k] = 1'b1;
        if (abort_p >= 0 && ep == abort_p && ph == 0) begin
          abort[k] = 1'b1;
          tick();
          abort[k] = 1'b0;
          r = model(k, fmode, abort_p);
          chk("abort_busy", busy[k], 0);
          chk("abort_done", done[k], 0);
          chk("abort_pattern", pat_of(k), 0);
          chk("abort_ones", ones[k], r.ones);
          chk("abort_sig", sig[k], r.sig);
          repeat (3) tick();
          chk("abort_no_done", done[k], 0);
          chk("abort_ones_frozen", ones[k], r.ones);
          chk("abort_sig_frozen", sig[k], r.sig);
          pat_q.delete();
          exp_q.delete();
          fin = 1'b1;
        end else if (reset_p >= 0 && ep == reset_p && ph == s) begin
          #2 rst_n[k] = 1'b0;
          #1;
          chk("rst_busy", busy[k], 0);
          chk("rst_done", done[k], 0);
          chk("rst_pattern", pat_of(k), 0);
          chk("rst_sig", sig[k], 0);
          chk("rst_ones", ones[k], 0);
          #1 rst_n[k] = 1'b1;
          pat_q.delete();
          exp_q.delete();
          fin = 1'b1;
        end
      end
      if (!fin) begin
        tick();
        start[k] = 1'b0;
        n++;
      end
    end
  endtask

  initial begin
    logic [15:0] sv;
    rst_n = '0; start = '0; abort = '0; f_in = '0;
    #2;
    for (int k = 0; k < NI; k++) begin
      chk("reset_busy", busy[k], 0);
      chk("reset_done", done[k], 0);
      chk("reset_pattern", pat_of(k), 0);
      chk("reset_sig", sig[k], 0);
      chk("reset_ones", ones[k], 0);
    end
    @(negedge clk);
    rst_n = '1;
    tick();

    // f_in tied 0, seed 0, settle 1
    start_sweep(0, 0);
    monitor(0, 0, 1'b0, -1, -1, -1, 1'b0);
    chk("zero_sig", sig[0], 16'h0000);
    chk("zero_ones", ones[0], 0);

    // f = a, settle 3
    start_sweep(1, 2);
    monitor(1, 2, 1'b0, -1, -1, -1, 1'b0);
    chk("fa_ones", ones[1], 32);
    repeat (4) tick();
    chk("fa_ones_hold", ones[1], 32);

    // f tied 1 with a second start at cycle 10
    start_sweep(2, 1);
    monitor(2, 1, 1'b0, 10, -1, -1, 1'b0);
    chk("one_ones", ones[2], 64);
    tick();

    // abort in HOLD at p=20
    start_sweep(2, 1);
    monitor(2, 1, 1'b0, -1, 20, -1, 1'b0);
    chk("abort_ones20", ones[2], 20);
    tick();

    // async reset mid-SAMPLE at p=40, then a fresh full sweep
    start_sweep(2, 1);
    monitor(2, 1, 1'b0, -1, -1, 40, 1'b0);
    tick();
    chk("post_rst_idle", busy[2], 0);
    tick();
    start_sweep(2, 2);
    monitor(2, 2, 1'b0, -1, -1, -1, 1'b0);
    tick();

    // noisy f_in outside SAMPLE, chained start in the DONE cycle
    start_sweep(2, 3);
    monitor(2, 3, 1'b1, -1, -1, -1, 1'b1);
    tick();
    start[2] = 1'b0;
    chk("chain_busy", busy[2], 1);
    chk("chain_sig_seed", sig[2], 16'hFFFF);
    chk("chain_ones", ones[2], 0);
    push_expect(2, 1);
    monitor(2, 1, 1'b0, -1, -1, -1, 1'b0);
    tick();

    // start and abort together in IDLE
    sv = sig[2];
    start[2] = 1'b1;
    abort[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    abort[2] = 1'b0;
    chk("sa_busy", busy[2], 0);
    tick();
    chk("sa_busy_later", busy[2], 0);
    chk("sa_sig_kept", sig[2], sv);
    chk("sa_ones_kept", ones[2], 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
